chunked_seq_adder: RTL and testbench
====================================

// Module: chunked_seq_adder
// PURPOSE
// Multi-cycle add/subtract unit, parametrised successor to the fixed 16-bit ripple adder.
// Adds CHUNK bits per clock using a registered inter-chunk carry.
// Completes a WIDTH-bit operation in WIDTH/CHUNK cycles, trading latency for a short carry path.
// Sits behind a start/busy/done handshake; results are held until the next operation completes.
// PARAMETERS
// WIDTH  16  operand/result width in bits; must be >= 2
// CHUNK  4   bits added per cycle; must divide WIDTH exactly (WIDTH/CHUNK = N steps)
// PORTS
// clk        input   1      rising-edge clock
// rst        input   1      synchronous reset, active-high
// start      input   1      request an operation; accepted only when busy=0
// byte_A     input   WIDTH  operand A, sampled on the accepting edge only
// byte_B     input   WIDTH  operand B, sampled on the accepting edge only
// carry_in   input   1      carry into bit 0 for add mode, sampled with operands
// sub_mode   input   1      0: A+B+carry_in; 1: A-B (A+~B+1, carry_in ignored), sampled with operands
// busy       output  1      high while an operation is in progress
// done       output  1      one-cycle pulse: result outputs updated this cycle
// byte_out   output  WIDTH  sum/difference, low WIDTH bits
// carry_out  output  1      raw carry out of bit WIDTH-1 (sub: 1 = no borrow)
// overflow   output  1      two's-complement signed overflow of the operation
// BEHAVIOUR
// - Reset (rst=1 at an edge): state=IDLE, chunk index=0, internal regs cleared.
//   Outputs after reset: busy=0, done=0, byte_out=0, carry_out=0, overflow=0.
//   rst overrides start and aborts any operation mid-flight; no done is produced for it.
// - States: IDLE, RUN, DONE.
// - IDLE/DONE, start=1 at edge E0: latch A, B (B inverted in sub mode) and carry (sub: 1, add: carry_in).
//   Then set idx=0 and go to RUN. start=0: go to/stay in IDLE.
// - RUN, each edge: add chunk idx: {A,B}[idx*CHUNK +: CHUNK] + carry_reg.
//   Write the sum into partial[idx*CHUNK +: CHUNK]; carry_reg <= chunk carry; idx <= idx+1.
// - On the edge processing chunk N-1 (edge E0+N):
//   byte_out <= completed partial; carry_out <= final carry; overflow <= final carry XOR carry into MSB.
//   Then go to DONE.
// - DONE lasts exactly one cycle (done=1), then IDLE, unless start is accepted on that edge (back-to-back).
// - Latency: done=1 and new results visible in the cycle after edge E0+N.
//   Throughput: one operation per N+1 cycles.
// - busy=1 exactly in RUN (cycles after E0 .. E0+N-1); done=1 exactly in DONE; never both high.
// - start while busy=1 is ignored; the in-flight operation is unaffected.
// - byte_out/carry_out/overflow change only on the completing edge; they hold prior values during RUN.
// - CHUNK=WIDTH (N=1): a single RUN cycle; all rules above still hold.
// - Operand inputs may change freely after the accepting edge.
// TESTING (WIDTH=16, CHUNK=4, N=4 unless stated)
// 1 Add wrap: A=FFFF, B=0001, cin=0, sub=0.
//   -> done exactly 4 cycles after the start edge; byte_out=0000, carry_out=1, overflow=0.
//   busy high for 4 cycles.
// 2 Signed overflow: A=7FFF, B=0001, add -> 8000, carry_out=0, overflow=1.
//   Then A=1234, B=4321, cin=1 -> 5556, carry_out=0, overflow=0.
// 3 Subtract: A=0005, B=0007, sub=1, cin=1 (ignored) -> FFFE, carry_out=0, overflow=0.
//   Then A=8000, B=0001 -> 7FFF, carry_out=1, overflow=1.
// 4 Handshake: start held high through RUN with different operands -> first result only.
//   Back-to-back start in the DONE cycle -> second done 5 cycles after the first.
//   Outputs stable during RUN.
// 5 Reset mid-op: rst=1 two cycles after start -> next cycle busy=0, done=0, byte_out=0.
//   No done pulse follows; a new start then works normally.
// 6 Params: WIDTH=8, CHUNK=8: 80+80 -> 00, carry_out=1, overflow=1, done 1 cycle after start.
//   WIDTH=32, CHUNK=1: FFFFFFFF+1 -> 0, carry_out=1, done after 32 cycles.

Source files
------------

// File: rtl/chunked_seq_adder.sv
// Module: chunked_seq_adder
// Multi-cycle add/subtract unit: adds CHUNK bits per clock with a registered carry between chunks.
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] byte_A,
    input  logic [WIDTH-1:0] byte_B,
    input  logic             carry_in,
    input  logic             sub_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] byte_out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] partial;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] completed;
    logic             last_step;
    logic             accept;
    logic             msb_carry_in;

    // Operands shift right one chunk per step, so the active chunk is always
    // the low CHUNK bits; sums enter the partial result from the top and
    // reach their final position after the last step.
    assign a_chunk      = a_reg[CHUNK-1:0];
    assign b_chunk      = b_reg[CHUNK-1:0];
    assign chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
    assign completed    = (partial >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    assign last_step    = (idx == LAST_IDX);
    assign accept       = start && (state != RUN);
    assign msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_step ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and result registers; results only move on the completing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            partial   <= '0;
            carry_reg <= 1'b0;
            byte_out  <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_reg     <= byte_A;
                b_reg     <= sub_mode ? ~byte_B : byte_B;
                carry_reg <= sub_mode | carry_in;
                idx       <= '0;
                partial   <= '0;
            end else if (state == RUN) begin
                a_reg     <= a_reg >> CHUNK;
                b_reg     <= b_reg >> CHUNK;
                partial   <= completed;
                carry_reg <= chunk_sum[CHUNK];
                idx       <= last_step ? '0 : idx + IDX_W'(1);
                if (last_step) begin
                    byte_out  <= completed;
                    carry_out <= chunk_sum[CHUNK];
                    overflow  <= chunk_sum[CHUNK] ^ msb_carry_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Testbench for chunked_seq_adder: cycle-by-cycle model comparison on the 16/4 instance
// plus directed literal checks, including the 8/8 and 32/1 parameterisations.
module tb_chunked_seq_adder;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] y;

    logic         start8 = 1'b0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         cin8 = 1'b0;
    logic         sub8 = 1'b0;
    logic         busy8, done8, cout8, ovf8;
    logic [7:0]   y8;

    logic         start32 = 1'b0;
    logic [31:0]  a32 = '0;
    logic [31:0]  b32 = '0;
    logic         cin32 = 1'b0;
    logic         sub32 = 1'b0;
    logic         busy32, done32, cout32, ovf32;
    logic [31:0]  y32;

    chunked_seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_A(a), .byte_B(b),
        .carry_in(cin), .sub_mode(sub), .busy(busy), .done(done),
        .byte_out(y), .carry_out(cout), .overflow(ovf)
    );

    chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .byte_A(a8), .byte_B(b8),
        .carry_in(cin8), .sub_mode(sub8), .busy(busy8), .done(done8),
        .byte_out(y8), .carry_out(cout8), .overflow(ovf8)
    );

    chunked_seq_adder #(.WIDTH(32), .CHUNK(1)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .byte_A(a32), .byte_B(b32),
        .carry_in(cin32), .sub_mode(sub32), .busy(busy32), .done(done32),
        .byte_out(y32), .carry_out(cout32), .overflow(ovf32)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference arithmetic: {carry_out, result}; subtraction carry means "no borrow".
    function automatic logic [W:0] modelResult(input logic [W-1:0] x, input logic [W-1:0] z,
                                               input logic ci, input logic sb);
        logic [W:0] r;
        if (sb) r = {(x >= z), x - z};
        else    r = {1'b0, x} + {1'b0, z} + (W+1)'(ci);
        return r;
    endfunction

    function automatic logic modelOverflow(input logic [W-1:0] x, input logic [W-1:0] z,
                                           input logic ci, input logic sb);
        longint sx, sz, cl, ex, maxv, minv;
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        cl = 0;
        if (ci) cl = 1;
        ex = sb ? (sx - sz) : (sx + sz + cl);
        maxv = (longint'(1) << (W - 1)) - 1;
        minv = -(longint'(1) << (W - 1));
        return (ex > maxv) || (ex < minv);
    endfunction

    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    bit           m_cout = 1'b0;
    bit           m_ovf = 1'b0;
    logic [W-1:0] m_out = '0;
    int           m_left = 0;
    logic [W:0]   p_res = '0;
    bit           p_ovf = 1'b0;

    // Transaction-level model: an accepted op stays busy for N cycles, then
    // publishes its result with a one-cycle done.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_out  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_left <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_out  <= p_res[W-1:0];
                m_cout <= p_res[W];
                m_ovf  <= p_ovf;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_left <= N;
                p_res  <= modelResult(a, b, cin, sub);
                p_ovf  <= modelOverflow(a, b, cin, sub);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({busy, done, y, cout, ovf} !== {m_busy, m_done, m_out, m_cout, m_ovf}) begin
                bad++;
                $display("[TB] FAIL cycle_compare t=%0t: dut busy=%b done=%b out=%h c=%b v=%b, model busy=%b done=%b out=%h c=%b v=%b",
                         $time, busy, done, y, cout, ovf, m_busy, m_done, m_out, m_cout, m_ovf);
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic ci, input logic sb);
        a = xa; b = xb; cin = ci; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'(
            $urandom); sub = 1'($urandom);
    endtask

    task automatic waitDone(input string name, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_done_seen"}, done, 1);
    endtask

    task automatic runOp(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic ci, input logic sb,
                         input logic [W-1:0] ey, input logic ec, input logic ev);
        int lat, bc;
        applyStimulus(xa, xb, ci, sb);
        waitDone(name, lat, bc);
        checkOutput({name, "_latency"}, lat, N);
        checkOutput({name, "_busy_cycles"}, bc, N);
        checkOutput({name, "_out"}, y, ey);
        checkOutput({name, "_carry"}, cout, ec);
        checkOutput({name, "_ovf"}, ovf, ev);
    endtask

    initial begin
        int lat, bc, dcount;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_out", y, 0);
        checkOutput("reset_carry", cout, 0);
        checkOutput("reset_ovf", ovf, 0);
        @(negedge clk);

        runOp("t1_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_done_pulse_width", done, 0);

        runOp("t2_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        @(negedge clk);
        runOp("t2_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        @(negedge clk);
        runOp("t3_sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        @(negedge clk);
        runOp("t3_subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        @(negedge clk);

        // start held high through RUN with changing operands
        a = 16'h0010; b = 16'h0020; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222;
        for (int k = 0; k < N; k++) begin
            checkOutput("t4_hold_out", y, 16'h7FFF);
            if (k == N - 1) start = 1'b0;
            @(negedge clk);
        end
        checkOutput("t4_first_done", done, 1);
        checkOutput("t4_first_out", y, 16'h0030);
        @(negedge clk);
        checkOutput("t4_no_restart", busy, 0);

        // back-to-back start in the DONE cycle
        applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0);
        waitDone("t4_b2b_first", lat, bc);
        checkOutput("t4_b2b_first_out", y, 16'h0003);
        a = 16'h0100; b = 16'h0200; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("t4_b2b_spacing", lat, 5);
        checkOutput("t4_b2b_second_out", y, 16'h0300);
        @(negedge clk);

        // reset two cycles after start
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_done", done, 0);
        checkOutput("t5_rst_out", y, 0);
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        checkOutput("t5_no_done_after_rst", dcount, 0);
        runOp("t5_after", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        @(negedge clk);

        // WIDTH=8, CHUNK=8
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        checkOutput("t6_w8_busy", busy8, 1);
        lat = 0;
        while (!done8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("t6_w8_latency", lat, 1);
        checkOutput("t6_w8_out", y8, 8'h00);
        checkOutput("t6_w8_carry", cout8, 1);
        checkOutput("t6_w8_ovf", ovf8, 1);

        // WIDTH=32, CHUNK=1
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("t6_w32_latency", lat, 32);
        checkOutput("t6_w32_out", y32, 32'h0);
        checkOutput("t6_w32_carry", cout32, 1);
        checkOutput("t6_w32_ovf", ovf32, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
